sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 33 +++
 rtl/sram_arbiter_wait_counter.sv | 41 ++++
 rtl/sram_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter that serves
// the fetch (IF) and data (MEM) sides of the pipeline.
package sram_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  // On a tie the side that was not granted last wins.
  function automatic gnt_e pick_grant(input logic if_req, input logic mem_req,
                                      input gnt_e last_gnt);
    gnt_e g;
    if (if_req && mem_req) begin
      g = (last_gnt == GNT_IF) ? GNT_MEM : GNT_IF;
    end else if (mem_req) begin
      g = GNT_MEM;
    end else begin
      g = GNT_IF;
    end
    return g;
  endfunction

endpackage

// File: rtl/sram_arbiter_wait_counter.sv
// Loadable down-counter timing the SRAM access window; saturates at zero.
module wait_counter
  import sram_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous SRAM between instruction fetch and data access;
// each transfer holds the SRAM for WAIT_CYCLES cycles then pulses ready once.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic [AW-1:0]     sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              freeze
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              last_q, last_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;
  logic              mem_req_s;
  logic              unused_addr_bits_s;

  assign mem_req_s          = mem_rd_en | mem_wr_en;
  assign unused_addr_bits_s = ^{if_addr, mem_addr};

  wait_counter #(.W(CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .dec_i      (cnt_dec_s),
    .load_val_i (LOAD_VAL),
    .zero_o     (cnt_zero_s)
  );

  // Next-state and datapath decode; SRAM strobes are computed from the
  // next state so the registered outputs are active exactly during ACC.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || mem_req_s) begin
          gnt_d      = pick_grant(if_req, mem_req_s, last_q);
          last_d     = gnt_d;
          addr_d     = (gnt_d == GNT_MEM) ? mem_addr[AW-1:0] : if_addr[AW-1:0];
          wdata_d    = mem_wdata;
          wr_d       = (gnt_d == GNT_MEM) && mem_wr_en;
          cnt_load_s = 1'b1;
          state_d    = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (cnt_zero_s) begin
          if (!wr_q && (gnt_q == GNT_IF)) begin
            if_rdata_d = sram_rdata;
          end else if (!wr_q) begin
            mem_rdata_d = sram_rdata;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
          if (gnt_q == GNT_IF) begin
            if_ready_d = 1'b1;
          end else begin
            mem_ready_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_dec_s = 1'b1;
          state_d   = ACC;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    oe_n_d = ~((state_d == ACC) && !wr_d);
    we_n_d = ~((state_d == ACC) && wr_d);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      last_q      <= GNT_IF;
      wr_q        <= 1'b0;
      addr_q      <= {AW{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      mem_rdata_q <= {DATA_W{1'b0}};
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_ready  = mem_ready_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;
  assign freeze     = (if_req & ~if_ready_q) | (mem_req_s & ~mem_ready_q);

endmodule
